me_stage_unit: RTL and testbench
================================

Name: me_stage_unit

Overview:
- Memory-access pipeline stage, placed between the execute stage and the writeback stage.
- Accepts one instruction per handshake from execute.
- For loads and stores, waits on the data-SRAM response. For loads, aligns and extends the read data.
- Drives the 70-bit bus to writeback and publishes forwarding/stall info to decode.

Parameters:
- BUS_IN_W, 75, width of the EX-to-ME bus
- BUS_OUT_W, 70, width of the ME-to-WB bus

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- EX_to_ME_Valid  in  1  upstream valid
- EX_to_ME_Bus  in  75  fields:
  - pc[74:43]
  - gr_we[42]
  - dest[41:37]
  - mem_req[36]: EX issued a data-SRAM request
  - res_from_mem[35]
  - ld_op[34:32]
  - alu_result[31:0]: also the address
- ME_Allow_in  out  1  stage can accept
- WB_Allow_in  in  1  downstream can accept
- ME_to_WB_Valid  out  1  downstream valid
- ME_to_WB_Bus  out  70  fields: pc[69:38], gr_we[37], dest[36:32], final_result[31:0]
- data_sram_rdata  in  32  response data
- data_sram_data_ok  in  1  response strobe, exactly one per issued request
- ME_Forward  out  38  fields: ME_dest[37:33] (0 when invalid), fwd_data[32:1], ME_load_pending[0]
- perf_mem_wait_cnt  out  32  see Optional Feature

Behaviour:
- Pipeline register: captures EX_to_ME_Bus when EX_to_ME_Valid && ME_Allow_in.
- Valid register:
  - reset → 0
  - else if ME_Allow_in → EX_to_ME_Valid
- Handshake signals:
  - ME_ReadyGo = !ME_Valid || !mem_req || state==DONE || (state==WAIT && data_sram_data_ok)
  - ME_Allow_in = !ME_Valid || (ME_ReadyGo && WB_Allow_in)
  - ME_to_WB_Valid = ME_Valid && ME_ReadyGo
- FSM, state encoding in package. Reset → IDLE.
  - IDLE:
    - Accepting an instruction with mem_req=1 → WAIT.
    - mem_req=0 → stays IDLE.
  - WAIT, on data_sram_data_ok:
    - If WB_Allow_in: complete same cycle. Next state is WAIT if a new mem_req instruction is accepted that cycle, else IDLE.
    - Else: latch data_sram_rdata into rdata_buf → DONE.
  - DONE:
    - Hold rdata_buf until WB_Allow_in.
    - Then → WAIT if a new mem_req instruction is accepted that cycle, else IDLE.
  - data_ok in IDLE or DONE: ignored. Covers stray responses after reset.
- Load data:
  - raw = (state==DONE) ? rdata_buf : data_sram_rdata
  - Byte select: alu_result[1:0]. Halfword select: alu_result[1].
  - ld_op encodings:
    - LD_W=000: raw
    - LD_B=001: sign-extended byte
    - LD_H=010: sign-extended half
    - LD_BU=101: zero-extended byte
    - LD_HU=110: zero-extended half
  - Unaligned addresses: no checking; low bits simply select.
- final_result = res_from_mem ? aligned load : alu_result. Stores use mem_req=1, res_from_mem=0.
- Forwarding:
  - ME_dest = dest & {5{ME_Valid && gr_we}}
  - fwd_data = final_result
  - ME_load_pending = ME_Valid && res_from_mem && !ME_ReadyGo
- Latency: one cycle for non-memory ops. Memory ops complete in the data_ok cycle, or later if buffered.
- Reset mid-WAIT: valid and FSM cleared. The late data_ok is discarded.

Optional Feature:
- Macro ME_PERF_CNT_EN.
- Defined: 32-bit counter, reset to 0, increments each cycle ME_Valid && state==WAIT && !data_sram_data_ok. Wraps 0xFFFFFFFF→0. Drives perf_mem_wait_cnt.
- Undefined: no counter logic; perf_mem_wait_cnt tied to 0.

Decomposition:
- Package me_pkg holds:
  - LD_W/LD_B/LD_H/LD_BU/LD_HU encodings
  - FSM state encoding (IDLE/WAIT/DONE)
  - bus-width constants (75/70/38)
  - bus field offset constants
- One sub-module: me_load_align. Purely combinational: raw data, addr[1:0], ld_op → 32-bit result.

Test Plan:
- ALU op (mem_req=0, pc=0x1C000000, dest=5, alu_result=0x12345678), WB_Allow_in=1 → next cycle ME_to_WB_Valid=1, bus = {0x1C000000, 1, 5, 0x12345678}.
- LD_B, addr low bits=2'b11, data_ok after 3 cycles with rdata=0x80FF00AA → ME_load_pending=1 for 3 cycles; final_result=0xFFFFFF80. Counter=3 when macro defined.
- LD_HU, addr[1]=1, rdata=0x9ABC1234 → final_result=0x00009ABC. LD_H with same inputs → 0xFFFF9ABC.
- data_ok arrives while WB_Allow_in=0 for 2 cycles → state DONE, rdata_buf held. On release, result is correct and ME_Allow_in=0 throughout the stall.
- Back-to-back loads with data_ok each cycle → one result per cycle, no bubbles, WAIT held.
- Assert reset during WAIT, then data_ok pulse → no ME_to_WB_Valid, state IDLE, all outputs zero/inactive.

Source files
------------

// File: rtl/me_stage_unit_pkg.sv
// rtl/me_stage_unit_pkg.sv - shared encodings, bus widths and field offsets for the memory stage
package me_pkg;

    localparam int ME_BUS_IN_W  = 75;
    localparam int ME_BUS_OUT_W = 70;
    localparam int ME_FWD_W     = 38;

    localparam int IN_PC_LSB        = 43;
    localparam int IN_GR_WE         = 42;
    localparam int IN_DEST_LSB      = 37;
    localparam int IN_MEM_REQ       = 36;
    localparam int IN_RES_FROM_MEM  = 35;
    localparam int IN_LD_OP_LSB     = 32;

    localparam int OUT_PC_LSB       = 38;
    localparam int OUT_GR_WE        = 37;
    localparam int OUT_DEST_LSB     = 32;

    localparam int FWD_DEST_LSB     = 33;
    localparam int FWD_DATA_LSB     = 1;

    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_B  = 3'b001,
        LD_H  = 3'b010,
        LD_BU = 3'b101,
        LD_HU = 3'b110
    } ld_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } me_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        logic        mem_req;
        logic        res_from_mem;
        logic [2:0]  ld_op;
        logic [31:0] alu_result;
    } ex_bus_t;

endpackage

// File: rtl/me_stage_unit_if.sv
// rtl/me_stage_unit_if.sv - EX/WB/data-SRAM/forwarding signal bundle of the memory stage
interface me_stage_unit_if;
    import me_pkg::*;

    logic                    EX_to_ME_Valid;
    logic [ME_BUS_IN_W-1:0]  EX_to_ME_Bus;
    logic                    ME_Allow_in;
    logic                    WB_Allow_in;
    logic                    ME_to_WB_Valid;
    logic [ME_BUS_OUT_W-1:0] ME_to_WB_Bus;
    logic [31:0]             data_sram_rdata;
    logic                    data_sram_data_ok;
    logic [ME_FWD_W-1:0]     ME_Forward;
    logic [31:0]             perf_mem_wait_cnt;

    modport master (
        output EX_to_ME_Valid, EX_to_ME_Bus, WB_Allow_in, data_sram_rdata, data_sram_data_ok,
        input  ME_Allow_in, ME_to_WB_Valid, ME_to_WB_Bus, ME_Forward, perf_mem_wait_cnt
    );

    modport slave (
        input  EX_to_ME_Valid, EX_to_ME_Bus, WB_Allow_in, data_sram_rdata, data_sram_data_ok,
        output ME_Allow_in, ME_to_WB_Valid, ME_to_WB_Bus, ME_Forward, perf_mem_wait_cnt
    );
endinterface

// File: rtl/me_stage_unit_load_align.sv
// rtl/me_stage_unit_load_align.sv - selects and extends the loaded byte/half/word by address low bits
module me_load_align
    import me_pkg::*;
(
    input  logic [31:0] raw_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  ld_op_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_i)
            2'd0:    byte_sel = raw_i[7:0];
            2'd1:    byte_sel = raw_i[15:8];
            2'd2:    byte_sel = raw_i[23:16];
            default: byte_sel = raw_i[31:24];
        endcase
        half_sel = addr_i[1] ? raw_i[31:16] : raw_i[15:0];

        case (ld_op_i)
            LD_W:    result_o = raw_i;
            LD_B:    result_o = {{24{byte_sel[7]}}, byte_sel};
            LD_H:    result_o = {{16{half_sel[15]}}, half_sel};
            LD_BU:   result_o = {24'd0, byte_sel};
            LD_HU:   result_o = {16'd0, half_sel};
            default: result_o = raw_i;
        endcase
    end

endmodule

// File: rtl/me_stage_unit.sv
// rtl/me_stage_unit.sv - memory-access pipeline stage; optional wait-cycle counter under ME_PERF_CNT_EN
module me_stage_unit
    import me_pkg::*;
#(
    parameter int BUS_IN_W  = ME_BUS_IN_W,
    parameter int BUS_OUT_W = ME_BUS_OUT_W
) (
    input  logic           clk,
    input  logic           reset,
    me_stage_unit_if.slave me_if
);

    logic                 valid_q, valid_d;
    logic [BUS_IN_W-1:0]  bus_q, bus_d;
    me_state_e            state_q, state_d;
    logic [31:0]          rdata_buf_q, rdata_buf_d;

    ex_bus_t              cur;
    logic                 ready_go;
    logic                 allow_in;
    logic                 accept;
    logic                 accept_mem;
    logic                 data_ok;
    logic                 wb_allow;
    logic [31:0]          raw_data;
    logic [31:0]          load_data;
    logic [31:0]          final_result;
    logic                 load_pending;
    logic [4:0]           fwd_dest;
    logic [BUS_OUT_W-1:0] out_bus;

    assign cur      = ex_bus_t'(bus_q);
    assign data_ok  = me_if.data_sram_data_ok;
    assign wb_allow = me_if.WB_Allow_in;

    // A response buffered in DONE must win over whatever the SRAM drives now.
    assign raw_data = (state_q == ST_DONE) ? rdata_buf_q : me_if.data_sram_rdata;

    me_load_align u_load_align (
        .raw_i    (raw_data),
        .addr_i   (cur.alu_result[1:0]),
        .ld_op_i  (cur.ld_op),
        .result_o (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            bus_q       <= '0;
            state_q     <= ST_IDLE;
            rdata_buf_q <= '0;
        end else begin
            valid_q     <= valid_d;
            bus_q       <= bus_d;
            state_q     <= state_d;
            rdata_buf_q <= rdata_buf_d;
        end
    end

    always_comb begin
        valid_d     = allow_in ? me_if.EX_to_ME_Valid : valid_q;
        bus_d       = accept ? me_if.EX_to_ME_Bus : bus_q;
        rdata_buf_d = rdata_buf_q;
        state_d     = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_mem) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (data_ok) begin
                    if (wb_allow) begin
                        state_d = accept_mem ? ST_WAIT : ST_IDLE;
                    end else begin
                        rdata_buf_d = me_if.data_sram_rdata;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (wb_allow) state_d = accept_mem ? ST_WAIT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready_go     = !valid_q || !cur.mem_req || (state_q == ST_DONE) ||
                       ((state_q == ST_WAIT) && data_ok);
        allow_in     = !valid_q || (ready_go && wb_allow);
        accept       = me_if.EX_to_ME_Valid && allow_in;
        accept_mem   = accept && me_if.EX_to_ME_Bus[IN_MEM_REQ];
        final_result = cur.res_from_mem ? load_data : cur.alu_result;
        load_pending = valid_q && cur.res_from_mem && !ready_go;
        fwd_dest     = cur.dest & {5{valid_q && cur.gr_we}};
        out_bus      = {cur.pc, cur.gr_we, cur.dest, final_result};
    end

    assign me_if.ME_Allow_in    = allow_in;
    assign me_if.ME_to_WB_Valid = valid_q && ready_go;
    assign me_if.ME_to_WB_Bus   = out_bus;
    assign me_if.ME_Forward     = {fwd_dest, final_result, load_pending};

`ifdef ME_PERF_CNT_EN
    logic [31:0] perf_cnt_q, perf_cnt_d;

    always_comb begin
        perf_cnt_d = perf_cnt_q;
        if (valid_q && (state_q == ST_WAIT) && !data_ok) perf_cnt_d = perf_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) perf_cnt_q <= '0;
        else       perf_cnt_q <= perf_cnt_d;
    end

    assign me_if.perf_mem_wait_cnt = perf_cnt_q;
`else
    assign me_if.perf_mem_wait_cnt = '0;
`endif

endmodule

// File: tb/tb_me_stage_unit.sv
// tb/tb_me_stage_unit.sv - scoreboard bench for me_stage_unit with directed and random instruction streams
module tb_me_stage_unit;
    import me_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        logic        mem_req;
        logic        res_from_mem;
        logic [2:0]  ld_op;
        logic [31:0] alu;
        logic [31:0] rdata;
        int          delay;
        int          wb_stall;
    } instr_t;

    localparam int N_DIR    = 9;
    localparam int N_RAND   = 300;
    localparam int CYC_MAX  = 20000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    me_stage_unit_if dut_if ();
    me_stage_unit dut (.clk(clk), .reset(reset), .me_if(dut_if));

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;
    instr_t      in_q[$];
    logic [69:0] sb[$];

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] exp_final(instr_t t);
        logic [31:0] b, h;
        int sh;
        if (!t.res_from_mem) return t.alu;
        sh = 8 * int'(t.alu[1:0]);
        b  = (t.rdata >> sh) & 32'h0000_00FF;
        h  = (t.rdata >> (t.alu[1] ? 16 : 0)) & 32'h0000_FFFF;
        case (t.ld_op)
            3'b001:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'b010:  return h[15] ? (h | 32'hFFFF_0000) : h;
            3'b101:  return b;
            3'b110:  return h;
            default: return t.rdata;
        endcase
    endfunction

    function automatic logic [74:0] pack_in(instr_t t);
        return {t.pc, t.gr_we, t.dest, t.mem_req, t.res_from_mem, t.ld_op, t.alu};
    endfunction

    function automatic logic [69:0] exp_bus(instr_t t);
        return {t.pc, t.gr_we, t.dest, exp_final(t)};
    endfunction

    function automatic instr_t mk(logic [31:0] pc, logic [4:0] dest, logic mem, logic res,
                                  logic [2:0] op, logic [31:0] alu, logic [31:0] rd,
                                  int dly, int stall);
        instr_t t;
        t.pc = pc; t.gr_we = !(mem && !res); t.dest = dest; t.mem_req = mem;
        t.res_from_mem = res; t.ld_op = op; t.alu = alu; t.rdata = rd;
        t.delay = dly; t.wb_stall = stall;
        return t;
    endfunction

    function automatic instr_t rand_instr();
        logic [2:0] ops [5];
        int kind;
        ops = '{3'b000, 3'b001, 3'b010, 3'b101, 3'b110};
        kind = int'($urandom_range(0, 3));
        return mk({$urandom} & 32'hFFFF_FFFC, 5'($urandom), kind != 0, kind >= 2,
                  ops[$urandom_range(0, 4)], $urandom, $urandom,
                  int'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
    endfunction

    // Monitor: every WB transfer must match the oldest accepted instruction.
    initial begin
        logic [69:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (!reset && dut_if.ME_to_WB_Valid && dut_if.WB_Allow_in) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL wb_unexpected: got %h expected none", dut_if.ME_to_WB_Bus);
                end else begin
                    e = sb.pop_front();
                    chk("wb_bus", dut_if.ME_to_WB_Bus, e);
                end
            end
        end
    end

    initial begin
        instr_t cur, ex_cur;
        logic in_me, have_ex, responded, stall_applied;
        logic data_ok_now, ready_m, wb_ok, allow_m;
        int countdown, wb_hold, issued;
        logic [31:0] exp_perf;

        in_me = 0; have_ex = 0; responded = 0; stall_applied = 0;
        countdown = 0; wb_hold = 0; issued = 0; exp_perf = 0;
        cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        ex_cur = cur;

        reset = 1'b1;
        dut_if.EX_to_ME_Valid = 0; dut_if.EX_to_ME_Bus = '0; dut_if.WB_Allow_in = 1;
        dut_if.data_sram_rdata = '0; dut_if.data_sram_data_ok = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_allow", 70'(dut_if.ME_Allow_in), 70'd1);
        chk("rst_valid", 70'(dut_if.ME_to_WB_Valid), 70'd0);
        chk("rst_fwd", 70'(dut_if.ME_Forward), 70'd0);
        chk("rst_perf", 70'(dut_if.perf_mem_wait_cnt), 70'd0);

        in_q.push_back(mk(32'h1C00_0000, 5, 0, 0, 3'b000, 32'h1234_5678, 0, 0, 0));
        in_q.push_back(mk(32'h1C00_0004, 6, 1, 1, 3'b001, 32'h0000_1003, 32'h80FF_00AA, 3, 0));
        in_q.push_back(mk(32'h1C00_0008, 7, 1, 1, 3'b110, 32'h0000_2002, 32'h9ABC_1234, 1, 0));
        in_q.push_back(mk(32'h1C00_000C, 8, 1, 1, 3'b010, 32'h0000_2002, 32'h9ABC_1234, 1, 0));
        in_q.push_back(mk(32'h1C00_0010, 9, 1, 1, 3'b000, 32'h0000_3000, 32'hDEAD_BEEF, 1, 2));
        in_q.push_back(mk(32'h1C00_0014, 10, 1, 1, 3'b101, 32'h0000_4001, 32'h0000_F100, 0, 0));
        in_q.push_back(mk(32'h1C00_0018, 11, 1, 1, 3'b000, 32'h0000_4004, 32'h0102_0304, 0, 0));
        in_q.push_back(mk(32'h1C00_001C, 12, 1, 1, 3'b110, 32'h0000_4006, 32'h8001_7FFF, 0, 0));
        in_q.push_back(mk(32'h1C00_0020, 13, 1, 0, 3'b000, 32'h0000_5000, 32'h5555_AAAA, 2, 0));
        for (int i = 0; i < N_RAND; i++) in_q.push_back(rand_instr());

        while ((in_q.size() > 0 || have_ex || in_me) && cyc < CYC_MAX) begin
            @(negedge clk);
            cyc++;
            data_ok_now = in_me && cur.mem_req && !responded && (countdown == 0);
            ready_m     = in_me && (!cur.mem_req || responded || data_ok_now);
            if (ready_m && !stall_applied) begin
                wb_hold = cur.wb_stall;
                stall_applied = 1;
            end
            wb_ok = (wb_hold == 0);
            if (wb_hold > 0) wb_hold--;
            if (!have_ex && in_q.size() > 0 && (issued < N_DIR || $urandom_range(0, 3) != 0)) begin
                ex_cur = in_q.pop_front();
                have_ex = 1;
                issued++;
            end
            dut_if.WB_Allow_in       = wb_ok;
            dut_if.data_sram_data_ok = data_ok_now;
            dut_if.data_sram_rdata   = data_ok_now ? cur.rdata : $urandom;
            dut_if.EX_to_ME_Valid    = have_ex;
            dut_if.EX_to_ME_Bus      = have_ex ? pack_in(ex_cur) : {$urandom, $urandom, 11'($urandom)};
            allow_m = !in_me || (ready_m && wb_ok);
            #1;
            chk("allow_in", 70'(dut_if.ME_Allow_in), 70'(allow_m));
            chk("wb_valid", 70'(dut_if.ME_to_WB_Valid), 70'(ready_m));
            chk("fwd_dest", 70'(dut_if.ME_Forward[37:33]), 70'((in_me && cur.gr_we) ? cur.dest : 5'd0));
            chk("load_pending", 70'(dut_if.ME_Forward[0]), 70'(in_me && cur.res_from_mem && !ready_m));
            if (ready_m) chk("fwd_data", 70'(dut_if.ME_Forward[32:1]), 70'(exp_final(cur)));
            chk("perf_cnt", 70'(dut_if.perf_mem_wait_cnt), 70'(exp_perf));

            if (in_me && cur.mem_req && !responded && !data_ok_now) begin
                countdown--;
`ifdef ME_PERF_CNT_EN
                exp_perf = exp_perf + 32'd1;
`endif
            end
            if (data_ok_now && !wb_ok) responded = 1;
            if (have_ex && allow_m) begin
                sb.push_back(exp_bus(ex_cur));
                cur = ex_cur; in_me = 1; responded = 0;
                countdown = cur.delay; stall_applied = 0; have_ex = 0;
            end else if (ready_m && wb_ok) begin
                in_me = 0;
            end
        end
        if (cyc >= CYC_MAX) begin
            n_vec++;
            n_fail++;
            $display("FAIL timeout: got %0d cycles expected under %0d", cyc, CYC_MAX);
        end

        // Reset while a load waits, then a stray response must vanish.
        @(negedge clk);
        dut_if.WB_Allow_in = 1; dut_if.data_sram_data_ok = 0;
        dut_if.EX_to_ME_Valid = 1;
        dut_if.EX_to_ME_Bus = pack_in(mk(32'h1C00_0100, 3, 1, 1, 3'b000, 32'h40, 0, 0, 0));
        @(negedge clk);
        dut_if.EX_to_ME_Valid = 0;
        #1;
        chk("wait_pending", 70'(dut_if.ME_Forward[0]), 70'd1);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        dut_if.data_sram_data_ok = 1;
        dut_if.data_sram_rdata = 32'hCAFE_F00D;
        #1;
        chk("rstw_valid", 70'(dut_if.ME_to_WB_Valid), 70'd0);
        chk("rstw_allow", 70'(dut_if.ME_Allow_in), 70'd1);
        chk("rstw_fwd", 70'(dut_if.ME_Forward), 70'd0);
        chk("rstw_perf", 70'(dut_if.perf_mem_wait_cnt), 70'd0);
        @(negedge clk);
        dut_if.data_sram_data_ok = 0;
        #1;
        chk("rstw_valid2", 70'(dut_if.ME_to_WB_Valid), 70'd0);
        chk("rstw_fwd2", 70'(dut_if.ME_Forward), 70'd0);
        chk("rstw_bus", 70'(dut_if.ME_to_WB_Bus), 70'd0);
        @(negedge clk);
        chk("sb_drained", 70'(sb.size()), 70'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
